uart_result_tx: RTL and testbench

UART_RESULT_TX -- requirements
Module: uart_result_tx

---
 rtl/uart_result_tx.sv | 138 +++++++++++++
 tb/tb_uart_result_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_tx.sv
// uart_result_tx
//   Serialises a 4-byte result frame onto an 8N1 UART line. The bytes go
//   out as load_data[7:0] first and load_data[31:24] last, with no idle gap
//   between them.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (2..4095)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   load_valid     requester offers a frame on load_data
//   load_data      {byte3, byte2, byte1, byte0}; byte0 is sent first
//   load_ready     high in IDLE; a frame is taken when load_valid && load_ready
//   tx_serial_out  registered UART line, idle high
//   busy           frame in progress (inverse of load_ready)
//   done           one-cycle pulse during the last cycle of byte 3's stop bit
//   byte_idx       index of the byte currently on the line
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | line high, waiting for a frame
// START | start bit (0) of byte byte_idx
// DATA  | data bit bit_idx of byte byte_idx, LSB first
// STOP  | stop bit (1) of byte byte_idx
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        tx_serial_out,
  output logic        busy,
  output logic        done,
  output logic [1:0]  byte_idx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [11:0] RELOAD = 12'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [11:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [31:0] frame_buf;

  logic        bit_end;
  logic [2:0]  next_bit_idx;

  // bit_cnt is a down-counter; the last cycle of every bit is bit_cnt == 0.
  assign bit_end      = (bit_cnt == 12'd0);
  assign next_bit_idx = bit_idx + 3'd1;

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tx_serial_out <= 1'b1;
      done          <= 1'b0;
      byte_idx      <= 2'd0;
      bit_idx       <= 3'd0;
      bit_cnt       <= 12'd0;
      frame_buf     <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial_out <= 1'b1;
          if (load_valid) begin
            frame_buf     <= load_data;
            state         <= START;
            tx_serial_out <= 1'b0;
            bit_cnt       <= RELOAD;
            byte_idx      <= 2'd0;
            bit_idx       <= 3'd0;
          end
        end

        START: begin
          if (bit_end) begin
            state         <= DATA;
            tx_serial_out <= frame_buf[{byte_idx, 3'd0}];
            bit_idx       <= 3'd0;
            bit_cnt       <= RELOAD;
          end else begin
            bit_cnt <= bit_cnt - 12'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_cnt <= RELOAD;
            if (bit_idx == 3'd7) begin
              state         <= STOP;
              tx_serial_out <= 1'b1;
            end else begin
              bit_idx       <= next_bit_idx;
              tx_serial_out <= frame_buf[{byte_idx, next_bit_idx}];
            end
          end else begin
            bit_cnt <= bit_cnt - 12'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (byte_idx == 2'd3) begin
              state         <= IDLE;
              tx_serial_out <= 1'b1;
              byte_idx      <= 2'd0;
            end else begin
              state         <= START;
              tx_serial_out <= 1'b0;
              byte_idx      <= byte_idx + 2'd1;
              bit_cnt       <= RELOAD;
            end
          end else begin
            bit_cnt <= bit_cnt - 12'd1;
            // Registered one cycle early so done lines up with the final
            // stop-bit cycle (CLKS_PER_BIT >= 2 guarantees bit_cnt hits 1).
            if (byte_idx == 2'd3 && bit_cnt == 12'd1)
              done <= 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          tx_serial_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx
//   Directed bench for uart_result_tx: one instance at CLKS_PER_BIT=10 for
//   the functional frames and reset abort, plus instances at 2 and 868 for
//   bit-width and frame-length measurement.
`timescale 1ns/1ps
module tb_uart_result_tx;

  localparam int CPB = 10;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready, tx, busy, done;
  logic [1:0]  byte_idx;

  logic        load_valid_s;
  logic [31:0] load_data_s;
  logic        ready2, tx2, busy2, done2;
  logic [1:0]  bidx2;
  logic        ready868, tx868, busy868, done868;
  logic [1:0]  bidx868;

  int n_checks = 0;
  int n_errors = 0;

  int low2, tot2, low868, tot868;
  int bad_rst;

  uart_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .tx_serial_out(tx), .busy(busy), .done(done),
    .byte_idx(byte_idx)
  );

  uart_result_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid_s), .load_data(load_data_s),
    .load_ready(ready2), .tx_serial_out(tx2), .busy(busy2), .done(done2),
    .byte_idx(bidx2)
  );

  uart_result_tx #(.CLKS_PER_BIT(868)) dut868 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid_s), .load_data(load_data_s),
    .load_ready(ready868), .tx_serial_out(tx868), .busy(busy868), .done(done868),
    .byte_idx(bidx868)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller sets load_valid/load_data at a negedge. The task waits for the
  // frame to be accepted, then walks all 40*CPB cycles comparing against the
  // 8N1 bit pattern of exp_data, and finishes at the first IDLE cycle.
  task automatic run_frame(input string name, input logic [31:0] exp_data,
                           input logic [31:0] data_after, input logic keep_valid);
    int w, b, k, pos;
    int bad_tx, bad_idx, bad_busy, done_cnt, done_at;
    logic exp_tx, first_tx;
    logic [7:0] rx [4];
    w = 0;
    while (!load_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check_val({name, "_ready_wait"}, 32'(w < 1000), 32'd1);
    @(negedge clk);
    load_data  = data_after;
    load_valid = keep_valid;
    bad_tx = 0; bad_idx = 0; bad_busy = 0; done_cnt = 0; done_at = -1;
    first_tx = 1'b1;
    for (int i = 0; i < 4; i++) rx[i] = 8'h00;
    for (int cyc = 0; cyc < 40 * CPB; cyc++) begin
      if (cyc > 0) @(negedge clk);
      b   = cyc / CPB;
      k   = b / 10;
      pos = b % 10;
      if (pos == 0)      exp_tx = 1'b0;
      else if (pos == 9) exp_tx = 1'b1;
      else               exp_tx = exp_data[k * 8 + pos - 1];
      if (cyc == 0) first_tx = tx;
      if (tx !== exp_tx) bad_tx++;
      if (byte_idx !== 2'(k)) bad_idx++;
      if (busy !== 1'b1 || load_ready !== 1'b0) bad_busy++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = cyc;
      end
      if ((cyc % CPB) == CPB / 2 && pos >= 1 && pos <= 8) rx[k][pos - 1] = tx;
    end
    check_val({name, "_first_low"}, 32'(first_tx), 32'd0);
    check_val({name, "_tx_bad_cycles"}, 32'(bad_tx), 32'd0);
    check_val({name, "_byte_idx_bad"}, 32'(bad_idx), 32'd0);
    check_val({name, "_busy_bad"}, 32'(bad_busy), 32'd0);
    check_val({name, "_done_count"}, 32'(done_cnt), 32'd1);
    check_val({name, "_done_cycle"}, 32'(done_at), 32'(40 * CPB - 1));
    for (int i = 0; i < 4; i++)
      check_val($sformatf("%s_rx_byte%0d", name, i), 32'(rx[i]), 32'(exp_data[i * 8 +: 8]));
    @(negedge clk);
    check_val({name, "_idle_tx"}, 32'(tx), 32'd1);
    check_val({name, "_idle_ready"}, 32'(load_ready), 32'd1);
    check_val({name, "_idle_done"}, 32'(done), 32'd0);
    check_val({name, "_idle_byte_idx"}, 32'(byte_idx), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    load_valid   = 1'b0;
    load_data    = 32'd0;
    load_valid_s = 1'b0;
    load_data_s  = 32'd0;
    repeat (3) @(negedge clk);

    check_val("rst_tx", 32'(tx), 32'd1);
    check_val("rst_ready", 32'(load_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_byte_idx", 32'(byte_idx), 32'd0);
    check_val("rst_sweep_lines", 32'({tx2, tx868}), 32'b11);
    check_val("rst_sweep_status", 32'({ready2, busy2, done2, bidx2, ready868, busy868, done868, bidx868}),
              32'b10000_10000);

    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_tx_after_release", 32'(tx), 32'd1);

    // Single frame, load_valid dropped after acceptance.
    load_valid = 1'b1;
    load_data  = 32'hFF00A355;
    run_frame("fA", 32'hFF00A355, 32'h0, 1'b0);

    // load_valid held with new data throughout: frame must stay intact, and
    // the next frame must start right after the single idle cycle.
    load_valid = 1'b1;
    load_data  = 32'hFF00A355;
    run_frame("fB", 32'hFF00A355, 32'h12345678, 1'b1);
    run_frame("fC", 32'h12345678, 32'h0, 1'b0);

    // Reset during byte 1 data bit 3 (A3 bit 3 = 0, so the line is low).
    load_valid = 1'b1;
    load_data  = 32'hFF00A355;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (14 * CPB + 2) @(negedge clk);
    check_val("abort_pre_tx", 32'(tx), 32'd0);
    check_val("abort_pre_byte_idx", 32'(byte_idx), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("abort_tx", 32'(tx), 32'd1);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_ready", 32'(load_ready), 32'd1);
    check_val("abort_byte_idx", 32'(byte_idx), 32'd0);
    bad_rst = 0;
    repeat (2) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad_rst++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad_rst++;
    end
    check_val("abort_quiet_cycles", 32'(bad_rst), 32'd0);
    load_valid = 1'b1;
    load_data  = 32'h04030201;
    run_frame("fR", 32'h04030201, 32'h0, 1'b0);

    // Parameter sweep: both instances accept at the same edge.
    load_valid_s = 1'b1;
    load_data_s  = 32'hFF00A355;
    @(negedge clk);
    load_valid_s = 1'b0;
    fork
      begin
        low2 = 0;
        while (tx2 === 1'b0 && low2 < 100) begin
          low2++;
          @(negedge clk);
        end
        tot2 = low2;
        while (busy2 === 1'b1 && tot2 < 200) begin
          tot2++;
          @(negedge clk);
        end
      end
      begin
        low868 = 0;
        while (tx868 === 1'b0 && low868 < 2000) begin
          low868++;
          @(negedge clk);
        end
        tot868 = low868;
        while (busy868 === 1'b1 && tot868 < 40000) begin
          tot868++;
          @(negedge clk);
        end
      end
    join
    check_val("c2_start_width", 32'(low2), 32'd2);
    check_val("c2_frame_len", 32'(tot2), 32'd80);
    check_val("c868_start_width", 32'(low868), 32'd868);
    check_val("c868_frame_len", 32'(tot868), 32'd34720);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
